// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster enable into vga_sync_gen, sync and position strobes out of it.
// VGA_SYNC_FRAME_COUNT_EN adds the frame_count signal.
interface vga_sync_gen_if;
    logic        enable;
    logic        h_sync;
    logic        v_sync;
    logic        bright;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        line_start;
    logic        frame_start;
`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic [15:0] frame_count;
    modport master (input enable, output h_sync, v_sync, bright, pixel_x, pixel_y,
                    line_start, frame_start, frame_count);
    modport slave (output enable, input h_sync, v_sync, bright, pixel_x, pixel_y,
                   line_start, frame_start, frame_count);
`else
    modport master (input enable, output h_sync, v_sync, bright, pixel_x, pixel_y,
                    line_start, frame_start);
    modport slave (output enable, input h_sync, v_sync, bright, pixel_x, pixel_y,
                   line_start, frame_start);
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA raster timing generator on the 25 MHz pixel clock.
// Defining VGA_SYNC_FRAME_COUNT_EN adds a 16-bit frame counter output.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic           clk_25,
    input  logic           reset_n,
    vga_sync_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_FP_AT = 10'(H_ACTIVE);
    localparam logic [9:0] H_SY_AT = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_BP_AT = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_FP_AT = 10'(V_ACTIVE);
    localparam logic [9:0] V_SY_AT = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_BP_AT = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_size
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_t;

    h_state_t   h_state, h_state_nxt;
    v_state_t   v_state, v_state_nxt;
    logic [9:0] h_count, v_count, h_nxt, v_nxt;
    logic       h_sync_q, v_sync_q, bright_q, line_start_q, frame_start_q;

    // Park is the last slot of the frame, so the first enabled edge lands on (0,0).
    always_comb begin
        h_nxt = !bus.enable ? H_LAST : (h_count == H_LAST ? '0 : h_count + 10'd1);
        v_nxt = !bus.enable ? V_LAST :
                (h_count != H_LAST ? v_count : (v_count == V_LAST ? '0 : v_count + 10'd1));
        h_state_nxt = h_state;
        v_state_nxt = v_state;
        if (!bus.enable) begin
            h_state_nxt = H_BP;
            v_state_nxt = V_BP;
        end else begin
            case (h_state)
                H_ACT: h_state_nxt = h_nxt == H_FP_AT ? H_FP : H_ACT;
                H_FP:  h_state_nxt = h_nxt == H_SY_AT ? H_SY : H_FP;
                H_SY:  h_state_nxt = h_nxt == H_BP_AT ? H_BP : H_SY;
                H_BP:  h_state_nxt = h_nxt == '0 ? H_ACT : H_BP;
            endcase
            case (v_state)
                V_ACT: v_state_nxt = v_nxt == V_FP_AT ? V_FP : V_ACT;
                V_FP:  v_state_nxt = v_nxt == V_SY_AT ? V_SY : V_FP;
                V_SY:  v_state_nxt = v_nxt == V_BP_AT ? V_BP : V_SY;
                V_BP:  v_state_nxt = v_nxt == '0 ? V_ACT : V_BP;
            endcase
        end
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            h_count       <= H_LAST;
            v_count       <= V_LAST;
            h_state       <= H_BP;
            v_state       <= V_BP;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            bright_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_count       <= h_nxt;
            v_count       <= v_nxt;
            h_state       <= h_state_nxt;
            v_state       <= v_state_nxt;
            h_sync_q      <= h_state_nxt != H_SY;
            v_sync_q      <= v_state_nxt != V_SY;
            bright_q      <= h_state_nxt == H_ACT && v_state_nxt == V_ACT;
            line_start_q  <= h_nxt == '0;
            frame_start_q <= h_nxt == '0 && v_nxt == '0;
        end
    end

    assign bus.h_sync      = h_sync_q;
    assign bus.v_sync      = v_sync_q;
    assign bus.bright      = bright_q;
    assign bus.pixel_x     = h_count;
    assign bus.pixel_y     = v_count;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n)
            frame_count_q <= '0;
        else if (!bus.enable)
            frame_count_q <= '0;
        else if (h_nxt == '0 && v_nxt == '0)
            frame_count_q <= frame_count_q + 16'd1;
    end

    assign bus.frame_count = frame_count_q;
`endif

    function automatic h_state_t h_phase(logic [9:0] x);
        return x < H_FP_AT ? H_ACT : x < H_SY_AT ? H_FP : x < H_BP_AT ? H_SY : H_BP;
    endfunction

    function automatic v_state_t v_phase(logic [9:0] y);
        return y < V_FP_AT ? V_ACT : y < V_SY_AT ? V_FP : y < V_BP_AT ? V_SY : V_BP;
    endfunction

    // Phase FSMs and counters are redundant encodings of the same position.
    a_phase_agree: assert property (@(posedge clk_25) disable iff (!reset_n)
        h_state == h_phase(h_count) && v_state == v_phase(v_count));
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks vga_sync_gen against a linear-pixel-index model, using a full-size
// instance for line timing and a scaled instance for frame-level timing.
module tb_vga_sync_gen;
    localparam int MT = 420000;
    localparam int ST = 408;

    typedef logic [24:0] obs_t;
    typedef struct {
        logic en;
        int   n;
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic br;
        logic ls;
        logic fs;
    } vec_t;

    localparam obs_t PARK = {1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b0};
    localparam obs_t ORIGIN = {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1};

    logic clk_25 = 1'b0;
    logic reset_n = 1'b0;
    always #20 clk_25 = ~clk_25;

    vga_sync_gen_if bus_m();
    vga_sync_gen_if bus_s();

    vga_sync_gen dut_m (.clk_25(clk_25), .reset_n(reset_n), .bus(bus_m));
    vga_sync_gen #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_s (.clk_25(clk_25), .reset_n(reset_n), .bus(bus_s));

    obs_t obs_m, obs_s;
    assign obs_m = {bus_m.h_sync, bus_m.v_sync, bus_m.bright, bus_m.pixel_x, bus_m.pixel_y,
                    bus_m.line_start, bus_m.frame_start};
    assign obs_s = {bus_s.h_sync, bus_s.v_sync, bus_s.bright, bus_s.pixel_x, bus_s.pixel_y,
                    bus_s.line_start, bus_s.frame_start};

    int tests = 0;
    int fails = 0;
    int tm, ts;
    logic [15:0] fcm, fcs;

    // Position is a single index t into the frame; everything else follows from x=t%H, y=t/H.
    function automatic obs_t model(int t, int ha, int hf, int hs, int hb, int va, int vf, int vs);
        int ht, x, y;
        ht = ha + hf + hs + hb;
        x = t % ht;
        y = t / ht;
        return {x < ha + hf || x >= ha + hf + hs, y < va + vf || y >= va + vf + vs,
                x < ha && y < va, 10'(x), 10'(y), x == 0, t == 0};
    endfunction

    task automatic check(string name, obs_t got, obs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got hs=%b vs=%b br=%b x=%0d y=%0d ls=%b fs=%b, expected hs=%b vs=%b br=%b x=%0d y=%0d ls=%b fs=%b",
                     name, got[24], got[23], got[22], got[21:12], got[11:2], got[1], got[0],
                     exp[24], exp[23], exp[22], exp[21:12], exp[11:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step(logic en_m, logic en_s);
        bus_m.enable = en_m;
        bus_s.enable = en_s;
        @(posedge clk_25);
        tm = en_m ? (tm + 1) % MT : MT - 1;
        ts = en_s ? (ts + 1) % ST : ST - 1;
        fcm = !en_m ? 16'd0 : (tm == 0 ? fcm + 16'd1 : fcm);
        fcs = !en_s ? 16'd0 : (ts == 0 ? fcs + 16'd1 : fcs);
        @(negedge clk_25);
        check("main_model", obs_m, model(tm, 640, 16, 96, 48, 480, 10, 2));
        check("small_model", obs_s, model(ts, 16, 2, 3, 3, 10, 2, 2));
`ifdef VGA_SYNC_FRAME_COUNT_EN
        check_int("main_frame_count", int'(bus_m.frame_count), int'(fcm));
        check_int("small_frame_count", int'(bus_s.frame_count), int'(fcs));
`endif
    endtask

    initial begin
        vec_t vecs[11];
        int br_n, hs_n, ls_n, hs_x, vs_n, vs_x, vs_y, fs_prev, fs_seen;
        vecs[0]  = '{1'b1, 1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 639, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1,   640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 15,  655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1,   656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 95,  751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1,   752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 47,  799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1,   0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1,   799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        bus_m.enable = 1'b0;
        bus_s.enable = 1'b0;
        tm = MT - 1;
        ts = ST - 1;
        fcm = '0;
        fcs = '0;
        #50;
        check("reset_state", obs_m, PARK);
        @(negedge clk_25);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            repeat (vecs[i].n) step(vecs[i].en, vecs[i].en);
            check($sformatf("vec%0d", i), obs_m, {vecs[i].hs, vecs[i].vs, vecs[i].br,
                  10'(vecs[i].x), 10'(vecs[i].y), vecs[i].ls, vecs[i].fs});
        end

        br_n = 0; hs_n = 0; ls_n = 0; hs_x = -1;
        repeat (800) begin
            step(1'b1, 1'b1);
            br_n += int'(bus_m.bright);
            ls_n += int'(bus_m.line_start);
            if (!bus_m.h_sync) begin
                if (hs_x < 0) hs_x = int'(bus_m.pixel_x);
                hs_n++;
            end
        end
        check_int("line_bright_clocks", br_n, 640);
        check_int("line_hsync_clocks", hs_n, 96);
        check_int("line_hsync_start_x", hs_x, 656);
        check_int("line_start_per_800", ls_n, 1);

        repeat (300) step(1'b1, 1'b1);
        check("pre_reset_x300", obs_m, {1'b1, 1'b1, 1'b1, 10'd300, 10'd1, 1'b0, 1'b0});
        #5 reset_n = 1'b0;
        #1;
        tm = MT - 1;
        ts = ST - 1;
        fcm = '0;
        fcs = '0;
        check("async_reset", obs_m, PARK);
        @(negedge clk_25);
        reset_n = 1'b1;
        step(1'b1, 1'b1);
        check("reset_release", obs_m, ORIGIN);

        repeat (45 * 800 + 123) step(1'b1, 1'b1);
        check("pos_123_45", obs_m, {1'b1, 1'b1, 1'b1, 10'd123, 10'd45, 1'b0, 1'b0});
        step(1'b0, 1'b1);
        check("enable_drop", obs_m, PARK);
        step(1'b1, 1'b1);
        check("enable_resume", obs_m, ORIGIN);

        step(1'b1, 1'b0);
        br_n = 0; vs_n = 0; vs_x = -1; vs_y = -1; fs_prev = -1; fs_seen = 0;
        for (int s = 1; s <= 817; s++) begin
            step(1'b1, 1'b1);
            if (s == 240) check("small_23_9", obs_s, {1'b1, 1'b1, 1'b0, 10'd23, 10'd9, 1'b0, 1'b0});
            if (s == 241) check("small_wrap_0_10", obs_s, {1'b1, 1'b1, 1'b0, 10'd0, 10'd10, 1'b1, 1'b0});
            if (s == 408) check("small_23_16", obs_s, {1'b1, 1'b1, 1'b0, 10'd23, 10'd16, 1'b0, 1'b0});
            if (s == 409) check("small_frame_wrap", obs_s, ORIGIN);
            if (bus_s.frame_start) begin
                fs_seen++;
                if (fs_prev >= 0) check_int("frame_interval", s - fs_prev, ST);
                fs_prev = s;
`ifdef VGA_SYNC_FRAME_COUNT_EN
                check_int("frame_count_seq", int'(bus_s.frame_count), fs_seen);
`endif
            end
            if (s <= 816) begin
                br_n += int'(bus_s.bright);
                if (!bus_s.v_sync) begin
                    if (vs_x < 0) begin
                        vs_x = int'(bus_s.pixel_x);
                        vs_y = int'(bus_s.pixel_y);
                    end
                    vs_n++;
                end
            end
        end
        check_int("frames_seen", fs_seen, 3);
        check_int("frame_bright_clocks", br_n, 2 * 160);
        check_int("frame_vsync_clocks", vs_n, 2 * 48);
        check_int("vsync_start_x", vs_x, 0);
        check_int("vsync_start_y", vs_y, 12);
        step(1'b0, 1'b0);
        check("small_disable", obs_s, {1'b1, 1'b1, 1'b0, 10'd23, 10'd16, 1'b0, 1'b0});
`ifdef VGA_SYNC_FRAME_COUNT_EN
        check_int("frame_count_clear", int'(bus_s.frame_count), 0);
`endif

        repeat (3000) step($urandom_range(0, 31) != 0, $urandom_range(0, 15) != 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
